// File: rtl/router_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : router_rx_pkg
// Brief    : Shared types for the router output-port receiver.
// Revision : 1.0
// ============================================================================
package router_rx_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } rx_state_e;

    typedef struct packed {
        logic [7:0] data;
        logic       sop;
        logic       eop;
        logic       err;
    } fifo_entry_t;

endpackage
`default_nettype wire

// File: rtl/router_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : router_rx_fifo
// Brief    : First-word fall-through FIFO; a write when full succeeds if a read
//            frees the slot in the same cycle.
// Revision : 1.0
// ============================================================================
module router_rx_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = router_rx_pkg::fifo_entry_t
) (
    input  logic clock,
    input  logic reset,
    input  logic wr_en,
    input  T     wr_data,
    input  logic rd_en,
    output T     rd_data,
    output logic empty,
    output logic full
);

    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CW = c_AW + 1;

    T                r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic            w_wr;
    logic            w_rd;

    assign empty   = (r_count == '0);
    assign full    = (r_count == c_CW'(DEPTH));
    assign w_rd    = rd_en & ~empty;
    assign w_wr    = wr_en & (~full | w_rd);
    assign rd_data = r_mem[r_rd_ptr];

    always_ff @(posedge clock) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/router_out_rx.sv
`default_nettype none
// ============================================================================
// Module   : router_out_rx
// Brief    : Deserialises one router output port (LSB first) into framed bytes.
// Revision : 1.0
// ============================================================================
module router_out_rx
    import router_rx_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        dout,
    input  logic        valido_n,
    input  logic        frameo_n,
    output logic [7:0]  byte_data,
    output logic        byte_sop,
    output logic        byte_eop,
    output logic        byte_err,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        busy,
    output logic [15:0] pkt_count,
    output logic [7:0]  drop_count,
    output logic        overflow
);

    rx_state_e   r_state, w_state_nxt;
    logic [2:0]  r_bit_cnt, w_bit_cnt_nxt;
    logic [7:0]  r_shift, w_shift_nxt;
    logic [7:0]  w_byte;
    logic        r_first, w_first_nxt;
    logic        r_armed;
    logic        r_wr_valid, w_wr_valid_nxt;
    fifo_entry_t r_wr_entry, w_wr_entry_nxt;
    fifo_entry_t w_head;
    logic        w_full, w_empty, w_rd, w_accept, w_drop;
    logic [15:0] r_pkt_count;
    logic [7:0]  r_drop_count;
    logic        r_overflow;

    assign w_byte = r_shift | (8'(dout) << r_bit_cnt);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_first    <= 1'b0;
            r_wr_valid <= 1'b0;
            r_wr_entry <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_first    <= w_first_nxt;
            r_wr_valid <= w_wr_valid_nxt;
            r_wr_entry <= w_wr_entry_nxt;
        end
    end

    // A frame already in flight when reset drops is ignored until the line idles.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_armed <= 1'b0;
        end else if (frameo_n) begin
            r_armed <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_first_nxt    = r_first;
        w_wr_valid_nxt = 1'b0;
        w_wr_entry_nxt = '0;
        case (r_state)
            IDLE: begin
                if (!frameo_n && r_armed) begin
                    w_state_nxt   = RECV;
                    w_first_nxt   = 1'b1;
                    w_bit_cnt_nxt = valido_n ? 3'd0 : 3'd1;
                    w_shift_nxt   = valido_n ? 8'h00 : w_byte;
                end
            end
            RECV: begin
                if (!valido_n) begin
                    if (frameo_n || (r_bit_cnt == 3'd7)) begin
                        w_wr_valid_nxt      = 1'b1;
                        w_wr_entry_nxt.data = w_byte;
                        w_wr_entry_nxt.sop  = r_first;
                        w_wr_entry_nxt.eop  = frameo_n;
                        w_wr_entry_nxt.err  = frameo_n && (r_bit_cnt != 3'd7);
                        w_first_nxt         = 1'b0;
                        w_bit_cnt_nxt       = 3'd0;
                        w_shift_nxt         = 8'h00;
                        if (frameo_n) begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_shift_nxt   = w_byte;
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    end
                end else if (frameo_n) begin
                    // Abort: flush whatever is held (zero when no bits arrived).
                    w_wr_valid_nxt      = 1'b1;
                    w_wr_entry_nxt.data = r_shift;
                    w_wr_entry_nxt.sop  = r_first;
                    w_wr_entry_nxt.eop  = 1'b1;
                    w_wr_entry_nxt.err  = 1'b1;
                    w_first_nxt         = 1'b0;
                    w_bit_cnt_nxt       = 3'd0;
                    w_shift_nxt         = 8'h00;
                    w_state_nxt         = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    router_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (fifo_entry_t)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (r_wr_valid),
        .wr_data (r_wr_entry),
        .rd_en   (w_rd),
        .rd_data (w_head),
        .empty   (w_empty),
        .full    (w_full)
    );

    assign w_rd     = ~w_empty & byte_ready;
    assign w_accept = r_wr_valid & (~w_full | w_rd);
    assign w_drop   = r_wr_valid & w_full & ~w_rd;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pkt_count  <= '0;
            r_drop_count <= '0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_accept && r_wr_entry.eop) begin
                r_pkt_count <= r_pkt_count + 16'd1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != 8'hFF) begin
                    r_drop_count <= r_drop_count + 8'd1;
                end
            end
        end
    end

    assign byte_data  = w_head.data;
    assign byte_sop   = w_head.sop;
    assign byte_eop   = w_head.eop;
    assign byte_err   = w_head.err;
    assign byte_valid = ~w_empty;
    assign busy       = (r_state != IDLE);
    assign pkt_count  = r_pkt_count;
    assign drop_count = r_drop_count;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire
